// File: rtl/vmem_pkg.sv
// Shared definitions for the vector memory address generator: default widths
// and the controller state encoding.
package vmem_pkg;

  localparam int WIDTH       = 32;
  localparam int LOG2NUMREGS = 3;
  localparam int MVL         = 64;
  localparam int LOG2MVL     = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/vmem_addrgen.sv
// Vector memory address generator: emits base + i*stride per handshake and
// optionally writes base + inc back to the base register file afterwards.
module vmem_addrgen
  import vmem_pkg::*;
#(
  parameter int WIDTH       = vmem_pkg::WIDTH,
  parameter int LOG2NUMREGS = vmem_pkg::LOG2NUMREGS,
  parameter int MVL         = vmem_pkg::MVL,
  parameter int LOG2MVL     = vmem_pkg::LOG2MVL
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       in_base,
  input  logic [WIDTH-1:0]       in_stride,
  input  logic [LOG2MVL:0]       in_vl,
  input  logic [LOG2NUMREGS-1:0] in_basereg,
  input  logic [LOG2NUMREGS-1:0] in_increg,
  input  logic                   in_postinc,
  output logic                   busy,
  output logic [LOG2NUMREGS-1:0] inc_a_reg,
  output logic                   inc_a_en,
  input  logic [WIDTH-1:0]       inc_readdata,
  output logic                   addr_valid,
  input  logic                   addr_ready,
  output logic [WIDTH-1:0]       addr,
  output logic [LOG2MVL-1:0]     addr_elem,
  output logic                   addr_last,
  output logic                   base_we,
  output logic [LOG2NUMREGS-1:0] base_reg,
  output logic [WIDTH-1:0]       base_writedata,
  output logic                   done
);

  localparam logic [LOG2MVL:0] MAX_VL = (LOG2MVL+1)'(MVL);
  localparam logic [LOG2MVL:0] ONE_VL = (LOG2MVL+1)'(1);

  state_t                   state, state_n;
  logic [WIDTH-1:0]         base_q;
  logic [WIDTH-1:0]         stride_q;
  logic [LOG2MVL:0]         vl_q;
  logic [LOG2NUMREGS-1:0]   basereg_q;
  logic                     postinc_q;
  logic [WIDTH-1:0]         cur_addr;
  logic [LOG2MVL-1:0]       elem_q;
  logic [WIDTH-1:0]         inc_q;
  logic                     inc_pending;
  logic                     zero_done_q;

  logic                     accept;
  logic                     handshake;
  logic                     is_last;
  logic [LOG2MVL:0]         vl_clamped;

  // Reset is folded into accept so no inc read can escape while held in reset.
  assign accept     = start & (state == ST_IDLE) & ~reset;
  assign vl_clamped = (in_vl > MAX_VL) ? MAX_VL : in_vl;
  assign is_last    = ({1'b0, elem_q} == (vl_q - ONE_VL));
  assign handshake  = (state == ST_GEN) & addr_ready;

  // NOTE: every signal driven here gets a default first so no latch is inferred
  // on paths the case statement does not mention.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (vl_clamped != '0) state_n = ST_GEN;
          else if (in_postinc)  state_n = ST_WB;
          else                  state_n = ST_IDLE;
        end
      end
      ST_GEN: begin
        if (handshake && is_last) state_n = postinc_q ? ST_WB : ST_IDLE;
      end
      ST_WB:   state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    busy           = 1'b0;
    inc_a_en       = 1'b0;
    inc_a_reg      = '0;
    addr_valid     = 1'b0;
    addr           = cur_addr;
    addr_elem      = elem_q;
    addr_last      = 1'b0;
    base_we        = 1'b0;
    base_reg       = '0;
    base_writedata = '0;
    done           = zero_done_q;

    if (accept && in_postinc) begin
      inc_a_en  = 1'b1;
      inc_a_reg = in_increg;
    end

    unique case (state)
      ST_GEN: begin
        busy       = 1'b1;
        addr_valid = 1'b1;
        addr_last  = is_last;
        if (handshake && is_last && !postinc_q) done = 1'b1;
      end
      ST_WB: begin
        busy           = 1'b1;
        base_we        = 1'b1;
        base_reg       = basereg_q;
        // The inc read lands here directly when WB follows accept immediately.
        base_writedata = base_q + (inc_pending ? inc_readdata : inc_q);
        done           = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      base_q      <= '0;
      stride_q    <= '0;
      vl_q        <= '0;
      basereg_q   <= '0;
      postinc_q   <= 1'b0;
      cur_addr    <= '0;
      elem_q      <= '0;
      inc_q       <= '0;
      inc_pending <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state       <= state_n;
      zero_done_q <= accept & (vl_clamped == '0) & ~in_postinc;

      if (inc_pending) begin
        inc_q       <= inc_readdata;
        inc_pending <= 1'b0;
      end

      if (accept) begin
        base_q      <= in_base;
        stride_q    <= in_stride;
        vl_q        <= vl_clamped;
        basereg_q   <= in_basereg;
        postinc_q   <= in_postinc;
        cur_addr    <= in_base;
        elem_q      <= '0;
        inc_pending <= in_postinc;
      end else if (handshake) begin
        cur_addr <= cur_addr + stride_q;
        elem_q   <= elem_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vmem_addrgen.sv
// Directed self-checking bench for vmem_addrgen with a small inc regfile model
// that returns read data one cycle after the read enable.
module tb_vmem_addrgen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] in_base;
  logic [31:0] in_stride;
  logic [6:0]  in_vl;
  logic [2:0]  in_basereg;
  logic [2:0]  in_increg;
  logic        in_postinc;
  logic        busy;
  logic [2:0]  inc_a_reg;
  logic        inc_a_en;
  logic [31:0] inc_readdata;
  logic        addr_valid;
  logic        addr_ready;
  logic [31:0] addr;
  logic [5:0]  addr_elem;
  logic        addr_last;
  logic        base_we;
  logic [2:0]  base_reg;
  logic [31:0] base_writedata;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] inc_rf [8];

  vmem_addrgen dut (
    .clk(clk), .reset(reset), .start(start),
    .in_base(in_base), .in_stride(in_stride), .in_vl(in_vl),
    .in_basereg(in_basereg), .in_increg(in_increg), .in_postinc(in_postinc),
    .busy(busy), .inc_a_reg(inc_a_reg), .inc_a_en(inc_a_en),
    .inc_readdata(inc_readdata), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr(addr), .addr_elem(addr_elem), .addr_last(addr_last),
    .base_we(base_we), .base_reg(base_reg), .base_writedata(base_writedata),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (inc_a_en) inc_readdata <= inc_rf[inc_a_reg];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request and follows it to done, checking every address beat.
  task automatic run_req(input string tag, input logic [31:0] base, input logic [31:0] stride,
                         input logic [6:0] vl, input logic [2:0] basereg, input logic [2:0] increg,
                         input logic postinc, input int ready_mode, input int exp_n,
                         input logic exp_wb, input logic [31:0] exp_wbdata, input int exp_done,
                         input int abort_hs, input bit poke);
    int   k        = 0;
    logic wb_seen  = 1'b0;
    int   done_cyc = -1;
    @(negedge clk);
    start      = 1'b1;
    in_base    = base;
    in_stride  = stride;
    in_vl      = vl;
    in_basereg = basereg;
    in_increg  = increg;
    in_postinc = postinc;
    #1;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_inc_en"}, 32'(inc_a_en), 32'(postinc));
    if (postinc) check({tag, "_inc_reg"}, 32'(inc_a_reg), 32'(increg));
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (abort_hs != 0 && k == abort_hs) return;
      addr_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 1);
      if (poke && cyc == 2) begin
        start      = 1'b1;
        in_postinc = 1'b1;
        in_base    = 32'hDEAD_BEEF;
      end
      if (poke && cyc == 3) start = 1'b0;
      #1;
      if (poke && cyc == 2) begin
        check({tag, "_busy_start_inc_en"}, 32'(inc_a_en), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
      end
      if (addr_valid) begin
        check({tag, "_addr"}, addr, base + 32'(k) * stride);
        check({tag, "_elem"}, 32'(addr_elem), 32'(k));
        check({tag, "_last"}, 32'(addr_last), 32'(k == exp_n - 1));
        if (addr_ready) k++;
      end
      if (base_we) begin
        wb_seen = 1'b1;
        check({tag, "_wb_data"}, base_writedata, exp_wbdata);
        check({tag, "_wb_reg"}, 32'(base_reg), 32'(basereg));
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    check({tag, "_count"}, 32'(k), 32'(exp_n));
    check({tag, "_wb_seen"}, 32'(wb_seen), 32'(exp_wb));
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
  endtask

  initial begin
    for (int r = 0; r < 8; r++) inc_rf[r] = 32'h0;
    inc_rf[3]    = 32'h40;
    inc_rf[5]    = 32'h100;
    inc_readdata = '0;
    reset        = 1'b1;
    start        = 1'b0;
    in_base      = '0;
    in_stride    = '0;
    in_vl        = '0;
    in_basereg   = '0;
    in_increg    = '0;
    in_postinc   = 1'b0;
    addr_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(addr_valid), 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_we", 32'(base_we), 32'd0);
    check("rst_wdata", base_writedata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_inc_en", 32'(inc_a_en), 32'd0);
    reset = 1'b0;

    // tag, base, stride, vl, basereg, increg, postinc, ready, n, wb, wbdata, done, abort, poke
    run_req("inc4",   32'h1000, 32'h4, 7'd4, 3'd1, 3'd3, 1'b1, 0, 4, 1'b1, 32'h1040, 5, 0, 1'b0);
    run_req("toggle", 32'h1000, 32'h4, 7'd4, 3'd1, 3'd3, 1'b1, 1, 4, 1'b1, 32'h1040, 8, 0, 1'b0);
    run_req("neg",    32'h10, 32'hFFFF_FFFC, 7'd3, 3'd2, 3'd0, 1'b0, 0, 3, 1'b0, 32'h0, 3, 0, 1'b1);
    run_req("vl0_r0", 32'h2000, 32'h4, 7'd0, 3'd4, 3'd0, 1'b1, 0, 0, 1'b1, 32'h2000, 1, 0, 1'b0);
    run_req("vl0_r3", 32'h2000, 32'h4, 7'd0, 3'd6, 3'd3, 1'b1, 0, 0, 1'b1, 32'h2040, 1, 0, 1'b0);
    run_req("vl0_np", 32'h2000, 32'h4, 7'd0, 3'd6, 3'd3, 1'b0, 0, 0, 1'b0, 32'h0, 1, 0, 1'b0);
    run_req("clamp",  32'h8000_0000, 32'h8, 7'd100, 3'd0, 3'd0, 1'b0, 0, 64, 1'b0, 32'h0, 64, 0, 1'b0);

    // Abandon a request mid-stream, then confirm a fresh one starts cleanly.
    run_req("abort",  32'h5000, 32'h4, 7'd8, 3'd7, 3'd3, 1'b1, 0, 8, 1'b1, 32'h5040, 9, 2, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(addr_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mid_rst_we", 32'(base_we), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_we", 32'(base_we), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);
    run_req("restart", 32'h3000, 32'h10, 7'd3, 3'd2, 3'd5, 1'b1, 0, 3, 1'b1, 32'h3100, 4, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
